// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-requester memory
//               arbiter. Grant IDs identify the fetch (I) and data (D)
//               requesters; request type encodings match the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Grant ID recorded per issued request and used to route responses.
    typedef enum logic [0:0] {
        ARB_ID_I = 1'b0,
        ARB_ID_D = 1'b1
    } arb_id_t;

    // Memory request type encoding.
    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    // Returns the requester that was not granted; used to rotate priority.
    function automatic arb_id_t arb_other(input arb_id_t id);
        return (id == ARB_ID_I) ? ARB_ID_D : ARB_ID_I;
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of every handshake/bus signal around the arbiter:
//               the fetch port (imem*), the data port (dmem*) and the shared
//               memory port (mem*).
//   master : the environment side (processor ports driving requests,
//            memory driving responses and memreq_rdy)
//   slave  : the arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;

    // Fetch requester
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_data;

    // Data requester
    logic        dmemreq_val;
    logic        dmemreq_rdy;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic        dmemresp_val;
    logic [31:0] dmemresp_data;

    // Shared memory port
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_wdata;
    logic        memresp_val;
    logic [31:0] memresp_data;

    modport master (
        output imemreq_val, imemreq_addr,
        input  imemreq_rdy, imemresp_val, imemresp_data,
        output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
        input  dmemreq_rdy, dmemresp_val, dmemresp_data,
        input  memreq_val, memreq_type, memreq_addr, memreq_wdata,
        output memreq_rdy, memresp_val, memresp_data
    );

    modport slave (
        input  imemreq_val, imemreq_addr,
        output imemreq_rdy, imemresp_val, imemresp_data,
        input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
        output dmemreq_rdy, dmemresp_val, dmemresp_data,
        output memreq_val, memreq_type, memreq_addr, memreq_wdata,
        input  memreq_rdy, memresp_val, memresp_data
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_tag_queue.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_tag_queue
// Description : Synchronous FIFO of grant IDs, one entry per outstanding
//               memory transaction. Head is presented combinationally so the
//               response demux can use it in the cycle the response arrives.
//               A push while full is accepted when a pop happens in the same
//               cycle (the popped slot is the one being rewritten).
//   clk     in   clock
//   rst     in   synchronous active-high reset (empties the queue)
//   push    in   enqueue push_id
//   push_id in   grant ID to enqueue
//   pop     in   dequeue head
//   head    out  oldest grant ID
//   count   out  number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_tag_queue
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  wire                          clk,
    input  wire                          rst,
    input  wire                          push,
    input  var arb_id_t                  push_id,
    input  wire                          pop,
    output arb_id_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    arb_id_t              r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_do_pop;
    logic                 w_do_push;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Popping an empty queue or pushing a full one without a pop are ignored.
    assign w_do_pop  = pop & (r_count != '0);
    assign w_do_push = push & ((r_count != c_depth) | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : mem_arb_tag_queue
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one in-order memory port between an instruction-fetch
//               requester and a data requester. Requests are granted
//               round-robin, the grant ID of every issued request is queued,
//               and each in-order response is routed back to its issuer.
//               Outstanding transactions are bounded by P_MAX_INFLIGHT.
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   bus  --   mem_arbiter_if.slave: imem*, dmem* and mem* handshakes
//   err  out  sticky flag: a memory response arrived with nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int P_MAX_INFLIGHT = 2
)
(
    input  wire             clk,
    input  wire             rst,
    mem_arbiter_if.slave    bus,
    output logic            err
);

    localparam int c_cnt_w = $clog2(P_MAX_INFLIGHT + 1);
    localparam logic [c_cnt_w-1:0] c_max_inflight = c_cnt_w'(P_MAX_INFLIGHT);

    arb_id_t              r_prio;
    logic                 r_err;

    arb_id_t              w_grant;
    arb_id_t              w_head;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_can_issue;
    logic                 w_any_req;
    logic                 w_fire;
    logic                 w_pop;
    logic                 w_stray;

    // ------------------------------------------------------------------
    // Grant selection. A lone requester always wins; a tie goes to the
    // priority pointer. Independent of memreq_rdy so memreq_val has no
    // combinational path from the memory's ready.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = r_prio;
        if (bus.imemreq_val && !bus.dmemreq_val) begin
            w_grant = ARB_ID_I;
        end else if (bus.dmemreq_val && !bus.imemreq_val) begin
            w_grant = ARB_ID_D;
        end
    end

    // A response arriving this cycle frees a slot, so a full queue can still
    // issue in the same cycle.
    assign w_can_issue = (w_count < c_max_inflight) | bus.memresp_val;
    assign w_any_req   = bus.imemreq_val | bus.dmemreq_val;

    assign bus.memreq_val   = w_can_issue & w_any_req;
    assign bus.memreq_type  = (w_grant == ARB_ID_D) ? bus.dmemreq_type  : MEMREQ_READ;
    assign bus.memreq_addr  = (w_grant == ARB_ID_D) ? bus.dmemreq_addr  : bus.imemreq_addr;
    assign bus.memreq_wdata = (w_grant == ARB_ID_D) ? bus.dmemreq_wdata : 32'h0;

    assign w_fire          = bus.memreq_val & bus.memreq_rdy;
    assign bus.imemreq_rdy = w_fire & (w_grant == ARB_ID_I);
    assign bus.dmemreq_rdy = w_fire & (w_grant == ARB_ID_D);

    // ------------------------------------------------------------------
    // Response routing: the queue head names the issuer of the oldest
    // outstanding request. Responses with nothing outstanding are dropped.
    // ------------------------------------------------------------------
    assign w_pop   = bus.memresp_val & (w_count != '0);
    assign w_stray = bus.memresp_val & (w_count == '0);

    assign bus.imemresp_val  = w_pop & (w_head == ARB_ID_I);
    assign bus.dmemresp_val  = w_pop & (w_head == ARB_ID_D);
    assign bus.imemresp_data = bus.memresp_data;
    assign bus.dmemresp_data = bus.memresp_data;

    mem_arb_tag_queue #(
        .DEPTH   (P_MAX_INFLIGHT)
    ) u_tag_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (w_fire),
        .push_id (w_grant),
        .pop     (w_pop),
        .head    (w_head),
        .count   (w_count)
    );

    // ------------------------------------------------------------------
    // Priority pointer and sticky error. Priority only rotates on an
    // actual issue so a stalled grant stays with the same requester.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= ARB_ID_D;
            r_err  <= 1'b0;
        end else begin
            if (w_fire) begin
                r_prio <= arb_other(w_grant);
            end
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Expected
//               responses are queued when a request is expected to issue and
//               compared when the memory model answers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        arb_id_t     id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic err;

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q[$];   // scoreboard: who should get each response
    logic [31:0] mem_q[$];   // memory model: data to return, in order

    int i_n;
    int d_n;
    int seq;

    mem_arbiter_if bus();

    mem_arbiter #(
        .P_MAX_INFLIGHT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imemreq_val   = 1'b0;
        bus.imemreq_addr  = 32'h0;
        bus.dmemreq_val   = 1'b0;
        bus.dmemreq_type  = MEMREQ_READ;
        bus.dmemreq_addr  = 32'h0;
        bus.dmemreq_wdata = 32'h0;
        bus.memreq_rdy    = 1'b0;
        bus.memresp_val   = 1'b0;
        bus.memresp_data  = 32'h0;
    endtask

    task automatic set_i(input logic [31:0] a);
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = a;
    endtask

    task automatic set_d(input logic t, input logic [31:0] a, input logic [31:0] w);
        bus.dmemreq_val   = 1'b1;
        bus.dmemreq_type  = t;
        bus.dmemreq_addr  = a;
        bus.dmemreq_wdata = w;
    endtask

    // Memory model returns the oldest outstanding transaction's data.
    task automatic mem_respond();
        bus.memresp_val = 1'b1;
        if (mem_q.size() > 0) bus.memresp_data = mem_q.pop_front();
        else                  bus.memresp_data = 32'hBAD0_BAD0;
    endtask

    task automatic expect_fire(input string tag, input arb_id_t id, input logic [31:0] addr,
                               input logic typ, input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        chk1({tag, ".memreq_val"}, bus.memreq_val, 1'b1);
        chk32({tag, ".memreq_addr"}, bus.memreq_addr, addr);
        chk1({tag, ".memreq_type"}, bus.memreq_type, typ);
        chk32({tag, ".memreq_wdata"}, bus.memreq_wdata, wdata);
        chk1({tag, ".imemreq_rdy"}, bus.imemreq_rdy, id == ARB_ID_I);
        chk1({tag, ".dmemreq_rdy"}, bus.dmemreq_rdy, id == ARB_ID_D);
        e.id   = id;
        e.data = rdata;
        exp_q.push_back(e);
        mem_q.push_back(rdata);
    endtask

    task automatic expect_blocked(input string tag);
        chk1({tag, ".memreq_val"}, bus.memreq_val, 1'b0);
        chk1({tag, ".imemreq_rdy"}, bus.imemreq_rdy, 1'b0);
        chk1({tag, ".dmemreq_rdy"}, bus.dmemreq_rdy, 1'b0);
    endtask

    task automatic expect_stall(input string tag, input logic [31:0] addr);
        chk1({tag, ".memreq_val"}, bus.memreq_val, 1'b1);
        chk32({tag, ".memreq_addr"}, bus.memreq_addr, addr);
        chk1({tag, ".imemreq_rdy"}, bus.imemreq_rdy, 1'b0);
        chk1({tag, ".dmemreq_rdy"}, bus.dmemreq_rdy, 1'b0);
    endtask

    task automatic expect_resp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=response expected=none_outstanding", tag);
        end else begin
            e = exp_q.pop_front();
            chk1({tag, ".imemresp_val"}, bus.imemresp_val, e.id == ARB_ID_I);
            chk1({tag, ".dmemresp_val"}, bus.dmemresp_val, e.id == ARB_ID_D);
            if (e.id == ARB_ID_I) chk32({tag, ".imemresp_data"}, bus.imemresp_data, e.data);
            else                  chk32({tag, ".dmemresp_data"}, bus.dmemresp_data, e.data);
        end
    endtask

    task automatic expect_no_resp(input string tag);
        chk1({tag, ".imemresp_val"}, bus.imemresp_val, 1'b0);
        chk1({tag, ".dmemresp_val"}, bus.dmemresp_val, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        expect_blocked("reset");
        expect_no_resp("reset");
        chk1("reset.err", err, 1'b0);

        // ---------------- fetch only ----------------
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        set_i(32'h200);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("fetch", ARB_ID_I, 32'h200, MEMREQ_READ, 32'h0, 32'hDEADBEEF);
        repeat (2) begin
            @(negedge clk);
            idle_inputs();
            #1;
            expect_no_resp("fetch.wait");
        end
        @(negedge clk);
        idle_inputs();
        mem_respond();
        #1;
        expect_resp("fetch.resp");

        // ---------------- round robin from reset ----------------
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_n = 0;
        d_n = 0;
        seq = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle_inputs();
            if (k < 4) begin
                set_i(32'h2000 + 32'(i_n * 4));
                set_d(logic'(d_n % 2), 32'h1000 + 32'(d_n * 4), 32'h5000 + 32'(d_n));
                bus.memreq_rdy = 1'b1;
            end
            if (k > 0) mem_respond();
            #1;
            if (k > 0) expect_resp($sformatf("rr.resp%0d", k));
            if (k < 4) begin
                if (k % 2 == 0) begin
                    expect_fire($sformatf("rr.grant%0d", k), ARB_ID_D, 32'h1000 + 32'(d_n * 4),
                                logic'(d_n % 2), 32'h5000 + 32'(d_n), 32'hA000_0000 + 32'(seq));
                    d_n++;
                end else begin
                    expect_fire($sformatf("rr.grant%0d", k), ARB_ID_I, 32'h2000 + 32'(i_n * 4),
                                MEMREQ_READ, 32'h0, 32'hA000_0000 + 32'(seq));
                    i_n++;
                end
                seq++;
            end
        end

        // ---------------- in-flight limit ----------------
        @(negedge clk);
        idle_inputs();
        set_i(32'h300);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("lim.a", ARB_ID_I, 32'h300, MEMREQ_READ, 32'h0, 32'hB000_0300);
        @(negedge clk);
        idle_inputs();
        set_d(MEMREQ_READ, 32'h304, 32'h0);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("lim.b", ARB_ID_D, 32'h304, MEMREQ_READ, 32'h0, 32'hB000_0304);
        @(negedge clk);
        idle_inputs();
        set_i(32'h308);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_blocked("lim.full");
        @(negedge clk);
        idle_inputs();
        set_i(32'h308);
        bus.memreq_rdy = 1'b1;
        mem_respond();
        #1;
        expect_resp("lim.pop");
        expect_fire("lim.same_cycle", ARB_ID_I, 32'h308, MEMREQ_READ, 32'h0, 32'hB000_0308);
        @(negedge clk);
        idle_inputs();
        set_d(MEMREQ_READ, 32'h30C, 32'h0);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_blocked("lim.still_full");
        @(negedge clk);
        idle_inputs();
        set_d(MEMREQ_READ, 32'h30C, 32'h0);
        bus.memreq_rdy = 1'b1;
        mem_respond();
        #1;
        expect_resp("lim.pop2");
        expect_fire("lim.refill", ARB_ID_D, 32'h30C, MEMREQ_READ, 32'h0, 32'hB000_030C);
        repeat (2) begin
            @(negedge clk);
            idle_inputs();
            mem_respond();
            #1;
            expect_resp("lim.drain");
        end

        // ---------------- memreq_rdy stall ----------------
        // Last issue was D, so I holds priority.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_inputs();
            set_i(32'h400);
            set_d(MEMREQ_WRITE, 32'h404, 32'h77);
            #1;
            expect_stall($sformatf("stall%0d", k), 32'h400);
        end
        @(negedge clk);
        idle_inputs();
        set_i(32'h400);
        set_d(MEMREQ_WRITE, 32'h404, 32'h77);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("stall.release", ARB_ID_I, 32'h400, MEMREQ_READ, 32'h0, 32'hC000_0400);
        @(negedge clk);
        idle_inputs();
        mem_respond();
        #1;
        expect_resp("stall.resp");

        // ---------------- stray response ----------------
        @(negedge clk);
        idle_inputs();
        bus.memresp_val  = 1'b1;
        bus.memresp_data = 32'h1234;
        #1;
        expect_no_resp("stray");
        chk1("stray.err_before_edge", err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk1($sformatf("stray.err_sticky%0d", k), err, 1'b1);
        end

        // ---------------- reset with outstanding tags ----------------
        @(negedge clk);
        idle_inputs();
        set_i(32'h600);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("rst.out_a", ARB_ID_I, 32'h600, MEMREQ_READ, 32'h0, 32'hD000_0600);
        @(negedge clk);
        idle_inputs();
        set_d(MEMREQ_READ, 32'h604, 32'h0);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("rst.out_b", ARB_ID_D, 32'h604, MEMREQ_READ, 32'h0, 32'hD000_0604);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        exp_q.delete();
        mem_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk1("rst.err_cleared", err, 1'b0);
        expect_no_resp("rst.idle");
        @(negedge clk);
        idle_inputs();
        set_i(32'h700);
        set_d(MEMREQ_READ, 32'h704, 32'h0);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("rst.prio_d", ARB_ID_D, 32'h704, MEMREQ_READ, 32'h0, 32'hE000_0704);
        @(negedge clk);
        idle_inputs();
        set_i(32'h700);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_fire("rst.second", ARB_ID_I, 32'h700, MEMREQ_READ, 32'h0, 32'hE000_0700);
        @(negedge clk);
        idle_inputs();
        set_d(MEMREQ_READ, 32'h708, 32'h0);
        bus.memreq_rdy = 1'b1;
        #1;
        expect_blocked("rst.count_restarted");

        // Reset again, then a stray response must raise err.
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        exp_q.delete();
        mem_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        bus.memresp_val  = 1'b1;
        bus.memresp_data = 32'h5555;
        #1;
        expect_no_resp("rst.stray");
        @(negedge clk);
        idle_inputs();
        #1;
        chk1("rst.stray_err", err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that shares one in-order memory port between the TinyRV1 pipeline's instruction-fetch port (imem) and data port (dmem). It sits between the processor and the single memory. It arbitrates requests round-robin and records the grant ID of every issued request in a tag queue. It then routes each in-order memory response back to the requester that issued it. It bounds outstanding transactions to a parameterised depth.

## Interface
- p_max_inflight, default 2: maximum outstanding memory transactions (tag queue depth, ≥1).

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imemreq_val  in  1  fetch request valid
- imemreq_rdy  out  1  fetch request accepted this cycle
- imemreq_addr  in  32  fetch byte address
- imemresp_val  out  1  fetch response valid
- imemresp_data  out  32  fetch response data
- dmemreq_val  in  1  data request valid
- dmemreq_rdy  out  1  data request accepted this cycle
- dmemreq_type  in  1  0 = read, 1 = write
- dmemreq_addr  in  32  data byte address
- dmemreq_wdata  in  32  store data
- dmemresp_val  out  1  data response valid
- dmemresp_data  out  32  data response data (undefined for writes)
- memreq_val  out  1  shared request valid
- memreq_rdy  in  1  memory accepts request
- memreq_type  out  1  read/write, forwarded
- memreq_addr  out  32  forwarded address
- memreq_wdata  out  32  forwarded store data (fetch: 0)
- memresp_val  in  1  memory response valid (in order, no backpressure)
- memresp_data  in  32  memory response data
- err  out  1  sticky protocol error flag

## Operation
- State: priority pointer `prio` (0 = I, 1 = D), tag queue of 1-bit grant IDs, occupancy count of width $clog2(p_max_inflight+1), sticky `err`.
- `can_issue` = (count < p_max_inflight) | memresp_val. Same-cycle pop frees a slot.
- Grant: if exactly one requester valid, grant it. If both valid, grant the one equal to `prio`. The grant is independent of memreq_rdy.
- memreq_val = can_issue & (imemreq_val | dmemreq_val). Fields are muxed from the granted requester. Fetch drives type = read and wdata = 0.
- Fire = memreq_val & memreq_rdy. Only the granted requester's *_rdy is 1, and only on fire.
- On fire: push the grant ID and set `prio` to the non-granted requester. Without a fire, `prio` holds.
- On memresp_val with count > 0: pop the head. Assert the head's *resp_val with data = memresp_data. The other *resp_val stays 0.
- On memresp_val with count = 0: response is dropped, no *resp_val is asserted, and `err` is set to 1 until rst.
- Simultaneous push and pop: count unchanged and queue order preserved. Writes consume a slot and return a response like reads.
- Requesters must hold *_val and fields stable until *_rdy.

## Timing
- Request path combinational, zero latency: requester inputs to memreq_* and memreq_rdy to *_rdy in the same cycle.
- No path from memreq_rdy to memreq_val.
- Response routing combinational, zero latency: memresp_* to *resp_* in the same cycle.
- Tag push/pop and `prio` update take effect at the next rising edge.
- Reset values:
  - State: count = 0, queue empty, `prio` = D, err = 0.
  - Outputs, with all inputs low: memreq_val = 0, imemreq_rdy = 0, dmemreq_rdy = 0, imemresp_val = 0, dmemresp_val = 0.
- Reset mid-operation discards all outstanding tags. The memory must be reset in the same cycle. A post-reset stray response sets `err`.

## Structure
- Shared package `mem_arb_pkg`:
  - typedef `arb_id_t` (1 bit) with constants ARB_ID_I = 0 and ARB_ID_D = 1.
  - Constants MEMREQ_READ = 0 and MEMREQ_WRITE = 1.
- Sub-module `mem_arb_tag_queue`: synchronous FIFO of `arb_id_t`, depth p_max_inflight.
  - Ports: push, pop, head, count.
  - Supports simultaneous push and pop when full.
- Top level holds the grant logic, the `prio` register, the response demux and `err`.

## Test plan
- Fetch only: imemreq addr 0x200, memreq_rdy = 1 → same cycle memreq_addr = 0x200 and imemreq_rdy = 1. Three cycles later memresp data 0xDEADBEEF → imemresp_val = 1 with data 0xDEADBEEF, dmemresp_val = 0.
- Both valid continuously from reset, memreq_rdy = 1, memory answering one cycle later → grant order D, I, D, I. Responses are routed to D, I, D, I in order.
- p_max_inflight = 2:
  - Two reads issue with no responses → third request sees memreq_val = 0 and *_rdy = 0.
  - A memresp arrives → the third request fires in that cycle and count stays 2.
- memreq_rdy held 0 for 4 cycles with both valid → memreq_addr stable, `prio` unchanged, no *_rdy asserted. On release the same requester fires.
- Stray response: memresp_val with count = 0 → no *resp_val, err = 1, and err stays 1 until rst.
- Reset with 2 outstanding → next cycle count = 0, `prio` = D, err = 0. A stray response then sets err.
